alu_srcb_ctrl: RTL
==================

// Module: alu_srcb_ctrl
// PURPOSE
//  Multicycle control sequencer that drives the 3-bit select of the 5-input ALU-B source mux
//  (000 regB, 001 const 4, 010 sign-ext imm, 011 imm<<2, 100 zero-ext shamt), together with
//  the datapath write enables for each instruction phase. It sits between the instruction
//  register fields and the datapath muxes and registers, and is the only block that writes those selects.
// PARAMETERS
//  MEM_WAIT  2  cycles per memory read (FETCH, MEM_RD); legal 1..7
// PORTS
//  clk           in   1  system clock, rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  opcode        in   6  IR[31:26], sampled in DECODE only
//  funct         in   6  IR[5:0], sampled in DECODE only
//  alu_srcb_sel  out  3  ALU-B mux select (encoding above)
//  alu_op        out  3  000 pass, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLL, 110 SRL, 111 SRA
//  mem_read      out  1  memory read strobe
//  mem_write     out  1  memory write strobe, one cycle
//  ir_write      out  1  IR load enable
//  pc_write      out  1  unconditional PC load
//  pc_write_cond out  1  PC load if (zero ^ branch_ne)
//  branch_ne     out  1  1 = bne, 0 = beq (valid with pc_write_cond)
//  pc_jump       out  1  PC source = jump target
//  reg_write     out  1  register-bank write enable
//  epc_write     out  1  EPC load; PC loads exception vector in the same cycle
//  state_out     out  4  current state code, for debug and verification
// BEHAVIOUR
//  - Moore machine: every output decodes from state reg + wait counter only; no input-to-output comb path.
//  - reset_n low: state=RESET (0), wait cnt=0, latched alu_op=000, all outputs 0, alu_srcb_sel=000.
//    Reset low mid-instruction aborts it immediately; no enable stays high after reset asserts.
//  - RESET(0): 1 cycle after reset_n rises -> FETCH.
//  - FETCH(1): mem_read=1, srcb=001, alu_op=ADD for MEM_WAIT cycles. On the last cycle ir_write=1
//    and pc_write=1, then -> DECODE. Counter reloads on every FETCH/MEM_RD entry.
//  - DECODE(2): srcb=011, alu_op=ADD (branch target). Latch funct-derived alu_op. Next state:
//      op 00, funct 20/21 ADD, 22/23 SUB, 24 AND, 25 OR -> EXEC_R(3)
//      op 00, funct 00 SLL, 02 SRL, 03 SRA              -> EXEC_SH(4)
//      op 08 addi -> EXEC_I(5); op 23 lw / 2B sw -> MEM_ADDR(6)
//      op 04 beq / 05 bne -> BRANCH(9); op 02 j -> JUMP(10); any other op/funct -> EXCPT(11)
//  - EXEC_R: srcb=000, latched op -> WB(12). EXEC_SH: srcb=100, op SLL/SRL/SRA -> WB.
//    EXEC_I: srcb=010, ADD -> WB. WB: reg_write=1 for 1 cycle -> FETCH.
//  - MEM_ADDR: srcb=010, ADD. lw -> MEM_RD(7); sw -> MEM_WR(8).
//    MEM_RD: mem_read=1 for MEM_WAIT cycles -> WB. MEM_WR: mem_write=1 for 1 cycle -> FETCH.
//  - BRANCH: srcb=000, SUB, pc_write_cond=1, branch_ne=(op==05), 1 cycle -> FETCH.
//  - JUMP: pc_write=1, pc_jump=1, 1 cycle -> FETCH.
//  - EXCPT: epc_write=1, pc_write=1, 1 cycle -> FETCH.
//  - Unlisted states and unassigned state codes 13..15 -> FETCH on the next edge, with all enables 0.
//  - At most one of pc_write/pc_write_cond and one of mem_read/mem_write are high in any cycle.
//  - Instruction cycle counts (MEM_WAIT=M): R/shift/addi 3+M; lw 3+2M; sw 3+M; beq/bne/j/exc 2+M.
// TESTING
//  1 reset_n low 3 cycles, release -> state 0 for 1 cycle, then 1; all outputs 0 while reset_n is low.
//  2 M=2, add (op 00, funct 20) -> states 1,1,2,3,12,1. srcb 001,001,011,000.
//    reg_write only in state 12; ir_write and pc_write on the 2nd FETCH cycle.
//  3 lw (op 23) -> states 1,1,2,6,7,7,12. srcb=010 in state 6; mem_read high in states 1 and 7.
//    sw (op 2B) -> mem_write for 1 cycle in state 8.
//  4 sll (op 00, funct 00) -> srcb=100, alu_op=101. bne (op 05) -> pc_write_cond=1, branch_ne=1,
//    alu_op=010, srcb=000.
//  5 op 3F, and separately op 00 with funct 3F -> EXCPT: epc_write=1 and pc_write=1 together
//    for 1 cycle, then FETCH.
//  6 Pull reset_n low during MEM_RD cycle 1 -> outputs 0 asynchronously; on release, restart at RESET.

Source files
------------

// File: rtl/alu_srcb_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_srcb_ctrl : multicycle Moore sequencer for the ALU-B select and datapath |
// |                 write enables.  Rev 1.0                                      |
// +----------------------------------------------------------------------------+
module alu_srcb_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_srcb_sel,
  output logic [2:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       pc_jump,
  output logic       reg_write,
  output logic       epc_write,
  output logic [3:0] state_out
);

  localparam logic [3:0] c_st_reset    = 4'd0;
  localparam logic [3:0] c_st_fetch    = 4'd1;
  localparam logic [3:0] c_st_decode   = 4'd2;
  localparam logic [3:0] c_st_exec_r   = 4'd3;
  localparam logic [3:0] c_st_exec_sh  = 4'd4;
  localparam logic [3:0] c_st_exec_i   = 4'd5;
  localparam logic [3:0] c_st_mem_addr = 4'd6;
  localparam logic [3:0] c_st_mem_rd   = 4'd7;
  localparam logic [3:0] c_st_mem_wr   = 4'd8;
  localparam logic [3:0] c_st_branch   = 4'd9;
  localparam logic [3:0] c_st_jump     = 4'd10;
  localparam logic [3:0] c_st_excpt    = 4'd11;
  localparam logic [3:0] c_st_wb       = 4'd12;

  localparam logic [2:0] c_op_pass = 3'b000;
  localparam logic [2:0] c_op_add  = 3'b001;
  localparam logic [2:0] c_op_sub  = 3'b010;
  localparam logic [2:0] c_op_and  = 3'b011;
  localparam logic [2:0] c_op_or   = 3'b100;
  localparam logic [2:0] c_op_sll  = 3'b101;
  localparam logic [2:0] c_op_srl  = 3'b110;
  localparam logic [2:0] c_op_sra  = 3'b111;

  localparam logic [2:0] c_srcb_reg   = 3'b000;
  localparam logic [2:0] c_srcb_four  = 3'b001;
  localparam logic [2:0] c_srcb_simm  = 3'b010;
  localparam logic [2:0] c_srcb_imm2  = 3'b011;
  localparam logic [2:0] c_srcb_shamt = 3'b100;

  localparam logic [2:0] c_wait_load = 3'(MEM_WAIT - 1);

  logic [3:0] r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_alu_op, w_alu_op_nxt;
  logic       r_is_sw, w_is_sw_nxt;
  logic       r_is_bne, w_is_bne_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= c_st_reset;
      r_cnt    <= 3'd0;
      r_alu_op <= c_op_pass;
      r_is_sw  <= 1'b0;
      r_is_bne <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_alu_op <= w_alu_op_nxt;
      r_is_sw  <= w_is_sw_nxt;
      r_is_bne <= w_is_bne_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = c_st_fetch;
    w_cnt_nxt    = r_cnt;
    w_alu_op_nxt = r_alu_op;
    w_is_sw_nxt  = r_is_sw;
    w_is_bne_nxt = r_is_bne;
    case (r_state)
      c_st_fetch: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = c_st_decode;
        end else begin
          w_state_nxt = c_st_fetch;
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      c_st_decode: begin
        // The IR fields are only trusted here; everything later uses the latched copies.
        w_is_sw_nxt  = (opcode == 6'h2B);
        w_is_bne_nxt = (opcode == 6'h05);
        case (funct)
          6'h20, 6'h21: w_alu_op_nxt = c_op_add;
          6'h22, 6'h23: w_alu_op_nxt = c_op_sub;
          6'h24:        w_alu_op_nxt = c_op_and;
          6'h25:        w_alu_op_nxt = c_op_or;
          6'h00:        w_alu_op_nxt = c_op_sll;
          6'h02:        w_alu_op_nxt = c_op_srl;
          6'h03:        w_alu_op_nxt = c_op_sra;
          default:      w_alu_op_nxt = c_op_pass;
        endcase
        case (opcode)
          6'h00: begin
            case (funct)
              6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: w_state_nxt = c_st_exec_r;
              6'h00, 6'h02, 6'h03:                      w_state_nxt = c_st_exec_sh;
              default:                                  w_state_nxt = c_st_excpt;
            endcase
          end
          6'h08:        w_state_nxt = c_st_exec_i;
          6'h23, 6'h2B: w_state_nxt = c_st_mem_addr;
          6'h04, 6'h05: w_state_nxt = c_st_branch;
          6'h02:        w_state_nxt = c_st_jump;
          default:      w_state_nxt = c_st_excpt;
        endcase
      end
      c_st_exec_r, c_st_exec_sh, c_st_exec_i: w_state_nxt = c_st_wb;
      c_st_mem_addr: w_state_nxt = r_is_sw ? c_st_mem_wr : c_st_mem_rd;
      c_st_mem_rd: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = c_st_wb;
        end else begin
          w_state_nxt = c_st_mem_rd;
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = c_st_fetch;
    endcase
    // Both memory-wait states count down from a fresh load on every entry.
    if ((w_state_nxt != r_state) &&
        ((w_state_nxt == c_st_fetch) || (w_state_nxt == c_st_mem_rd))) begin
      w_cnt_nxt = c_wait_load;
    end
  end

  always_comb begin
    alu_srcb_sel  = c_srcb_reg;
    alu_op        = c_op_pass;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_jump       = 1'b0;
    reg_write     = 1'b0;
    epc_write     = 1'b0;
    case (r_state)
      c_st_fetch: begin
        alu_srcb_sel = c_srcb_four;
        alu_op       = c_op_add;
        mem_read     = 1'b1;
        ir_write     = (r_cnt == 3'd0);
        pc_write     = (r_cnt == 3'd0);
      end
      c_st_decode: begin
        alu_srcb_sel = c_srcb_imm2;
        alu_op       = c_op_add;
      end
      c_st_exec_r: begin
        alu_srcb_sel = c_srcb_reg;
        alu_op       = r_alu_op;
      end
      c_st_exec_sh: begin
        alu_srcb_sel = c_srcb_shamt;
        alu_op       = r_alu_op;
      end
      c_st_exec_i, c_st_mem_addr: begin
        alu_srcb_sel = c_srcb_simm;
        alu_op       = c_op_add;
      end
      c_st_mem_rd: mem_read  = 1'b1;
      c_st_mem_wr: mem_write = 1'b1;
      c_st_branch: begin
        alu_srcb_sel  = c_srcb_reg;
        alu_op        = c_op_sub;
        pc_write_cond = 1'b1;
        branch_ne     = r_is_bne;
      end
      c_st_jump: begin
        pc_write = 1'b1;
        pc_jump  = 1'b1;
      end
      c_st_excpt: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
      end
      c_st_wb: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign state_out = r_state;

endmodule
`default_nettype wire
